// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says datapath: colour encoding,
// segment array geometry and the sequence player state encoding.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam int NUM_SEGMENTS = 33;
    localparam int MAX_LEN      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } player_state_t;

    function automatic logic [3:0] colour_onehot(input colour_t c);
        logic [3:0] result;
        case (c)
            2'd0:    result = 4'b0001;
            2'd1:    result = 4'b0010;
            2'd2:    result = 4'b0100;
            2'd3:    result = 4'b1000;
            default: result = 4'b0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter with terminal-count flag; holds at zero instead of
// wrapping so the flag stays asserted until the next load.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Counter register: soft clear, then load, then count down towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (srst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/sequence_player.sv
// Plays a snapshot of the colour sequence on the LEDs, oldest first, with a
// lit phase and a dark gap per colour; handshakes via start/busy/done.
module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [5:0]                  length,
    input  colour_t [NUM_SEGMENTS-1:0]  segment,
    output logic [3:0]                  led,
    output logic                        busy,
    output logic                        done,
    output logic [5:0]                  index
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [5:0]    LEN_CAP  = 6'(MAX_LEN);

    player_state_t              state_r, state_nxt;
    colour_t [NUM_SEGMENTS-1:0] snap_r, snap_nxt;
    logic [5:0]                 pos_r, pos_nxt;
    logic [5:0]                 idx_nxt;
    logic [5:0]                 len_s;
    logic [3:0]                 led_nxt;
    logic                       busy_nxt;
    logic                       done_nxt;
    logic                       tmr_load_s;
    logic [TW-1:0]              tmr_value_s;
    logic                       tmr_enable_s;
    logic                       tmr_tc_s;

    assign len_s        = (length > LEN_CAP) ? LEN_CAP : length;
    assign tmr_enable_s = (state_r == ON) || (state_r == GAP);

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (reset_n),
        .srst       (abort),
        .load       (tmr_load_s),
        .enable     (tmr_enable_s),
        .load_value (tmr_value_s),
        .tc         (tmr_tc_s)
    );

    // Next-state logic; abort always beats start and timer expiry.
    always_comb begin
        state_nxt   = state_r;
        snap_nxt    = snap_r;
        pos_nxt     = pos_r;
        idx_nxt     = index;
        tmr_load_s  = 1'b0;
        tmr_value_s = ON_LOAD;
        case (state_r)
            IDLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    snap_nxt = segment;
                    if (len_s == 6'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = ON;
                        pos_nxt     = len_s;
                        idx_nxt     = 6'd1;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = ON_LOAD;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ON: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pos_nxt   = 6'd0;
                    idx_nxt   = 6'd0;
                end else if (tmr_tc_s) begin
                    state_nxt   = GAP;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = OFF_LOAD;
                end else begin
                    state_nxt = ON;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pos_nxt   = 6'd0;
                    idx_nxt   = 6'd0;
                end else if (tmr_tc_s) begin
                    if (pos_r == 6'd1) begin
                        state_nxt = DONE;
                        pos_nxt   = 6'd0;
                        idx_nxt   = 6'd0;
                    end else begin
                        state_nxt   = ON;
                        pos_nxt     = pos_r - 6'd1;
                        idx_nxt     = index + 6'd1;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = ON_LOAD;
                    end
                end else begin
                    state_nxt = GAP;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                pos_nxt   = 6'd0;
                idx_nxt   = 6'd0;
            end
            default: begin
                state_nxt = IDLE;
                pos_nxt   = 6'd0;
                idx_nxt   = 6'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        led_nxt  = 4'b0000;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt == ON) begin
            led_nxt  = colour_onehot(snap_nxt[pos_nxt]);
            busy_nxt = 1'b1;
        end else if (state_nxt == GAP) begin
            busy_nxt = 1'b1;
        end else if (state_nxt == DONE) begin
            done_nxt = 1'b1;
        end else begin
            led_nxt = 4'b0000;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            snap_r  <= {NUM_SEGMENTS{2'b00}};
            pos_r   <= 6'd0;
            index   <= 6'd0;
            led     <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt;
            snap_r  <= snap_nxt;
            pos_r   <= pos_nxt;
            index   <= idx_nxt;
            led     <= led_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// Directed, table-driven bench for sequence_player with ON_CYCLES=4, OFF_CYCLES=2.
module tb_sequence_player;
    import simon_pkg::*;

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic [5:0] index;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       start;
    logic                       abort;
    logic [5:0]                 length;
    colour_t [NUM_SEGMENTS-1:0] segment;
    logic [3:0]                 led;
    logic                       busy;
    logic                       done;
    logic [5:0]                 index;

    int   total = 0;
    int   bad   = 0;
    vec_t exp_tab [0:20];

    sequence_player #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .length  (length),
        .segment (segment),
        .led     (led),
        .busy    (busy),
        .done    (done),
        .index   (index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t observed();
        vec_t v;
        v.led   = led;
        v.busy  = busy;
        v.done  = done;
        v.index = index;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [3:0] l, input logic b, input logic [5:0] i);
        for (int c = lo; c <= hi; c++) begin
            exp_tab[c].led   = l;
            exp_tab[c].busy  = b;
            exp_tab[c].done  = 1'b0;
            exp_tab[c].index = i;
        end
    endtask

    task automatic load_len3();
        for (int k = 0; k < NUM_SEGMENTS; k++) segment[k] = 2'd0;
        segment[1] = 2'd2;
        segment[2] = 2'd0;
        segment[3] = 2'd3;
        length = 6'd3;
    endtask

    // mode 0: plain; 1: rewrite inputs in cycle 5; 2: start pulses in GAP/DONE, then restart
    task automatic play_check(input int mode, input string name);
        load_len3();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("%s_c%0d", name, c), {20'd0, observed()}, {20'd0, exp_tab[c]});
            if (mode == 1 && c == 5) begin
                for (int k = 0; k < NUM_SEGMENTS; k++) segment[k] = 2'd1;
                length = 6'd40;
            end
            start = (mode == 2 && (c == 5 || c == 19 || c == 20)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        if (mode == 2) begin
            check({name, "_restart"}, {20'd0, observed()}, {20'd0, 4'b1000, 1'b1, 1'b0, 6'd1});
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic abort_check(input int at, input string name);
        vec_t e;
        load_len3();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            e = (c <= at) ? exp_tab[c] : vec_t'(12'd0);
            check($sformatf("%s_c%0d", name, c), {20'd0, observed()}, {20'd0, e});
            abort = (c == at) ? 1'b1 : 1'b0;
            tick();
        end
        abort = 1'b0;
    endtask

    initial begin
        vec_t e;
        int   c;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        length  = 6'd0;
        for (int k = 0; k < NUM_SEGMENTS; k++) segment[k] = 2'd0;

        // Expected trace of the length-3 playback (slots 1..3 = 2,0,3)
        for (int k = 0; k <= 20; k++) exp_tab[k] = vec_t'(12'd0);
        fill(1, 4, 4'b1000, 1'b1, 6'd1);
        fill(5, 6, 4'b0000, 1'b1, 6'd1);
        fill(7, 10, 4'b0001, 1'b1, 6'd2);
        fill(11, 12, 4'b0000, 1'b1, 6'd2);
        fill(13, 16, 4'b0100, 1'b1, 6'd3);
        fill(17, 18, 4'b0000, 1'b1, 6'd3);
        exp_tab[19].done = 1'b1;

        #1;
        check("reset_state", {20'd0, observed()}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", {20'd0, observed()}, 32'd0);

        play_check(0, "len3");
        play_check(1, "snapshot");
        play_check(2, "start_ignored");

        // Zero length: done in cycle 1, never busy
        length = 6'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("len0_c1", {20'd0, observed()}, {20'd0, 4'b0000, 1'b0, 1'b1, 6'd0});
        tick();
        check("len0_c2", {20'd0, observed()}, 32'd0);

        // Length 40 clamps to 32 colours of 6 cycles each
        for (int k = 0; k < NUM_SEGMENTS; k++) segment[k] = 2'd1;
        length = 6'd40;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (c = 1; c <= 193; c++) begin
            if (c <= 192) begin
                e.led   = (((c - 1) % 6) < 4) ? 4'b0010 : 4'b0000;
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.index = 6'((c - 1) / 6 + 1);
            end else begin
                e = vec_t'(12'd0);
                e.done = 1'b1;
            end
            check($sformatf("len40_c%0d", c), {20'd0, observed()}, {20'd0, e});
            tick();
        end
        check("len40_after", {20'd0, observed()}, 32'd0);

        abort_check(8, "abort_on");
        abort_check(6, "abort_gap_tc");

        // Abort together with start in IDLE: no capture
        load_len3();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", {20'd0, observed()}, 32'd0);
        tick();
        check("abort_start_idle2", {20'd0, observed()}, 32'd0);

        // Asynchronous reset in the middle of a lit phase
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_on", {20'd0, observed()}, {20'd0, 4'b1000, 1'b1, 1'b0, 6'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_led", {28'd0, led}, 32'd0);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        tick();
        check("post_reset_idle", {20'd0, observed()}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
